bt656_video_encoder: RTL and testbench

- Converts a YCbCr 4:2:2 pixel stream from the pixel pipeline into an ITU-R BT.656 byte stream, with one byte per clock and embedded EAV/SAV timing codes.
- Also generates active-low HS/VS strobes and alternates the F (field) bit each field.
- It is the transmit end of the TD_DATA/TD_HS/TD_VS interface consumed by the video-in decoder. It is used as a loopback/test source and for driving external video encoders.
- Runs on the 27 MHz video clock.

---
 rtl/bt656_video_encoder_if.sv | 14 +
 rtl/bt656_video_encoder.sv | 119 +++++++++++
 tb/tb_bt656_video_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt656_video_encoder_if.sv
// Pixel-stream side of the BT.656 encoder: YCbCr 4:2:2 pixels {Y, C} with a
// start-of-frame marker, offered by the pixel pipeline to the encoder.
interface bt656_video_encoder_if;
  // A pixel transfers on a clock edge where in_valid && in_ready are both high.
  // The source holds in_data/in_startofpacket while in_valid is high and the
  // pixel has not transferred. in_ready may depend on in_valid/in_startofpacket.
  logic [15:0] in_data;
  logic        in_startofpacket;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_startofpacket, output in_valid, input in_ready);
  modport slave  (input in_data, input in_startofpacket, input in_valid, output in_ready);
endinterface

// File: rtl/bt656_video_encoder.sv
// ITU-R BT.656 transmitter: serialises 4:2:2 pixels into one byte per clock
// with EAV/SAV timing codes, active-low HS/VS strobes and a toggling F bit.
module bt656_video_encoder #(
  parameter int H_ACTIVE      = 720,
  parameter int H_BLANK_BYTES = 268,
  parameter int V_TOTAL       = 262,
  parameter int V_ACTIVE      = 240,
  parameter int V_SYNC        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  bt656_video_encoder_if.slave pix,
  output logic [7:0]           td_data,
  output logic                 td_hs,
  output logic                 td_vs,
  output logic                 field,
  output logic                 underflow,
  output logic                 synced
);
  localparam int LB           = 2 * H_ACTIVE + H_BLANK_BYTES + 8;
  localparam int SAV_BC       = H_BLANK_BYTES + 4;
  localparam int ACT_BC       = H_BLANK_BYTES + 8;
  localparam int VBLANK_LINES = V_TOTAL - V_ACTIVE;
  localparam int BC_W         = $clog2(LB);
  localparam int LN_W         = $clog2(V_TOTAL);

  typedef enum logic {ST_HUNT, ST_LOCKED} sync_state_e;

  sync_state_e     state_q;
  logic [BC_W-1:0] bc_q, bc_d, act_off;
  logic [LN_W-1:0] ln_q, ln_d;
  logic            f_q, f_d;
  logic [7:0]      y_q, y_d, data_d, xy;
  logic            hs_d, vs_d, uf_d;
  logic            v_bit, h_bit, in_code, c_slot, y_slot, frame_first, pix_sop, emit;
  logic [1:0]      code_idx, code_off;

  assign synced = (state_q == ST_LOCKED);

  always_comb begin
    v_bit       = (ln_q < LN_W'(VBLANK_LINES));
    h_bit       = (bc_q < BC_W'(4));
    in_code     = h_bit || (bc_q >= BC_W'(SAV_BC) && bc_q < BC_W'(ACT_BC));
    code_off    = 2'(bc_q - BC_W'(SAV_BC));
    code_idx    = h_bit ? bc_q[1:0] : code_off;
    xy          = {1'b1, f_q, v_bit, h_bit, v_bit ^ h_bit, f_q ^ h_bit, f_q ^ v_bit, f_q ^ v_bit ^ h_bit};
    act_off     = bc_q - BC_W'(ACT_BC);
    c_slot      = !v_bit && (bc_q >= BC_W'(ACT_BC)) && !act_off[0];
    y_slot      = !v_bit && (bc_q >= BC_W'(ACT_BC)) && act_off[0];
    frame_first = c_slot && (ln_q == LN_W'(VBLANK_LINES)) && (act_off == '0);
    pix_sop     = pix.in_valid && pix.in_startofpacket;

    // A held SOP pixel is refused everywhere except the frame-first slot.
    pix.in_ready = 1'b0;
    if (c_slot) pix.in_ready = (synced && frame_first) ? pix.in_valid : !pix_sop;
    emit = c_slot && synced && pix.in_valid &&
           (frame_first ? pix.in_startofpacket : !pix.in_startofpacket);

    bc_d = bc_q + 1'b1;
    ln_d = ln_q;
    f_d  = f_q;
    if (bc_q == BC_W'(LB - 1)) begin
      bc_d = '0;
      if (ln_q == LN_W'(V_TOTAL - 1)) begin
        ln_d = '0;
        f_d  = !f_q;
      end else begin
        ln_d = ln_q + 1'b1;
      end
    end

    y_d  = y_q;
    uf_d = 1'b0;
    if (in_code) begin
      data_d = (code_idx == 2'd0) ? 8'hFF : (code_idx == 2'd3) ? xy : 8'h00;
    end else if (c_slot) begin
      data_d = emit ? pix.in_data[7:0] : 8'h80;
      y_d    = emit ? pix.in_data[15:8] : 8'h10;
      uf_d   = synced && !pix.in_valid;
    end else if (y_slot) begin
      data_d = y_q;
    end else begin
      // Blanking regions start on even byte counts, so bc parity picks 80/10.
      data_d = bc_q[0] ? 8'h10 : 8'h80;
    end
    hs_d = (bc_q >= BC_W'(ACT_BC));
    vs_d = !(ln_q < LN_W'(V_SYNC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      bc_q      <= '0;
      ln_q      <= '0;
      f_q       <= 1'b0;
      y_q       <= 8'h10;
      td_data   <= 8'h00;
      td_hs     <= 1'b1;
      td_vs     <= 1'b1;
      field     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (state_q == ST_HUNT) begin
        if (c_slot && pix_sop) state_q <= ST_LOCKED;
      end else if (frame_first && pix.in_valid && !pix.in_startofpacket) begin
        state_q <= ST_HUNT;
      end
      bc_q      <= bc_d;
      ln_q      <= ln_d;
      f_q       <= f_d;
      y_q       <= y_d;
      td_data   <= data_d;
      td_hs     <= hs_d;
      td_vs     <= vs_d;
      field     <= f_q;
      underflow <= uf_d;
    end
  end
endmodule

// File: tb/tb_bt656_video_encoder.sv
// Bench for bt656_video_encoder: cycle-indexed reference model feeding an
// expected-byte queue, an output monitor, and directed checks on captured lines.
module tb_bt656_video_encoder;
  localparam int HA  = 4;
  localparam int HB  = 4;
  localparam int VT  = 6;
  localparam int VA  = 3;
  localparam int VS  = 1;
  localparam int LB  = 2 * HA + HB + 8;
  localparam int FLD = LB * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] td_data;
  logic       td_hs, td_vs, field, underflow, synced;

  bt656_video_encoder_if pix ();

  bt656_video_encoder #(
    .H_ACTIVE(HA), .H_BLANK_BYTES(HB), .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC(VS)
  ) dut (
    .clk(clk), .reset(reset), .pix(pix), .td_data(td_data), .td_hs(td_hs),
    .td_vs(td_vs), .field(field), .underflow(underflow), .synced(synced)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];    // {td_data, td_hs, td_vs, field, underflow}
  logic [11:0] act_log[$];
  logic [16:0] src_q[$];    // {sop, Y, C}
  int valid_pct = 100;
  int gap_at = -1;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_td_data"}, td_data, 0);
    chk({tag, "_td_hs"}, td_hs, 1);
    chk({tag, "_td_vs"}, td_vs, 1);
    chk({tag, "_field"}, field, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_in_ready"}, pix.in_ready, 0);
    chk({tag, "_synced"}, synced, 0);
  endtask

  task automatic assert_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset(tag);
    src_q.delete();
    gap_at = -1;
    valid_pct = 100;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int t = 0;
    while (act_log.size() < n && t < 5000) begin
      @(posedge clk);
      #3;
      t++;
    end
    checks++;
    if (act_log.size() < n) begin
      errors++;
      $display("FAIL wait_log: got %0d entries expected %0d", act_log.size(), n);
    end
  endtask

  task automatic push_frame(input int n, input logic [7:0] ybase, input logic [7:0] cbase);
    for (int i = 0; i < n; i++)
      src_q.push_back({(i == 0), 8'(ybase + i), 8'(cbase + i)});
  endtask

  function automatic logic [7:0] log_byte(input int i);
    return act_log[i][11:4];
  endfunction

  function automatic int count_uf(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (act_log[i][0]) c++;
    return c;
  endfunction

  // ---------------- driver ----------------
  initial begin : driver
    logic took;
    pix.in_valid = 1'b0;
    pix.in_data = 16'h0;
    pix.in_startofpacket = 1'b0;
    forever begin
      @(negedge clk);
      took = !reset && pix.in_valid && pix.in_ready;
      @(posedge clk);
      #2;
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      if (reset) begin
        cyc = 0;
        pix.in_valid = 1'b0;
      end else begin
        pix.in_valid = (src_q.size() > 0) && (cyc != gap_at) && ($urandom_range(99) < valid_pct);
        if (src_q.size() > 0) begin
          pix.in_startofpacket = src_q[0][16];
          pix.in_data = src_q[0][15:0];
        end
        cyc++;
      end
    end
  end

  // ---------------- reference model ----------------
  initial begin : model
    int m_n, bc, ln, k, a;
    logic m_synced, f, v, h, rdy, uf, emit, vld, sop;
    logic [7:0] m_y, b, xy;
    m_n = 0;
    m_synced = 1'b0;
    m_y = 8'h10;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_n = 0;
        m_synced = 1'b0;
        m_y = 8'h10;
      end else begin
        bc = m_n % LB;
        ln = (m_n / LB) % VT;
        f = ((m_n / FLD) % 2) == 1;
        v = ln < VT - VA;
        h = bc < 4;
        rdy = 1'b0;
        uf = 1'b0;
        if (bc < 4 || (bc >= HB + 4 && bc < HB + 8)) begin
          k = h ? bc : bc - (HB + 4);
          xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
          b = (k == 0) ? 8'hFF : (k == 3) ? xy : 8'h00;
        end else if (bc < HB + 8) begin
          b = ((bc - 4) % 2 == 0) ? 8'h80 : 8'h10;
        end else if (v) begin
          b = ((bc - (HB + 8)) % 2 == 0) ? 8'h80 : 8'h10;
        end else begin
          a = bc - (HB + 8);
          if (a % 2 == 1) begin
            b = m_y;
          end else begin
            vld = pix.in_valid;
            sop = pix.in_startofpacket;
            emit = 1'b0;
            if (!m_synced) begin
              rdy = !(vld && sop);
              if (vld && sop) m_synced = 1'b1;
            end else if (ln == VT - VA && a == 0) begin
              rdy = vld;
              uf = !vld;
              emit = vld && sop;
              if (vld && !sop) m_synced = 1'b0;
            end else begin
              rdy = !(vld && sop);
              uf = !vld;
              emit = vld && !sop;
            end
            b = emit ? pix.in_data[7:0] : 8'h80;
            m_y = emit ? pix.in_data[15:8] : 8'h10;
          end
        end
        checks++;
        if (pix.in_ready !== rdy) begin
          errors++;
          $display("FAIL in_ready n=%0d: got %b expected %b", m_n, pix.in_ready, rdy);
        end
        exp_q.push_back({b, (bc >= HB + 8), !(ln < VS), f, uf});
        m_n++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [11:0] e, act;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        act_log.delete();
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {td_data, td_hs, td_vs, field, underflow};
        act_log.push_back(act);
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL stream idx=%0d: got data=%h hs=%b vs=%b f=%b uf=%b expected data=%h hs=%b vs=%b f=%b uf=%b",
                   act_log.size() - 1, act[11:4], act[3], act[2], act[1], act[0],
                   e[11:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus / directed checks ----------------
  initial begin : main
    logic [7:0] line0 [20];
    logic [7:0] l3act [8];
    int t;
    line0 = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
              8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};
    l3act = '{8'h60, 8'h50, 8'h61, 8'h51, 8'h62, 8'h52, 8'h63, 8'h53};

    // Idle stream: timing codes, sync strobes, field toggle
    #1;
    assert_reset("rst_init");
    release_reset();
    wait_log(240);
    for (int i = 0; i < 20; i++) chk($sformatf("idle_line0_b%0d", i), log_byte(i), line0[i]);
    chk("idle_l3_eav", log_byte(63), 8'h9D);
    chk("idle_l3_sav", log_byte(71), 8'h80);
    chk("idle_vs_l0_first", act_log[0][2], 0);
    chk("idle_vs_l0_last", act_log[19][2], 0);
    chk("idle_vs_l1", act_log[20][2], 1);
    chk("idle_field_end_f0", act_log[119][1], 0);
    chk("idle_field_start_f1", act_log[120][1], 1);
    chk("f1_l0_eav", log_byte(123), 8'hF1);
    chk("f1_l0_sav", log_byte(131), 8'hEC);
    chk("f1_l3_eav", log_byte(183), 8'hDA);
    chk("f1_l3_sav", log_byte(191), 8'hC7);
    chk("idle_uf_count", count_uf(0, 239), 0);

    // Continuous SOP frame
    assert_reset("rst_b");
    push_frame(12, 8'h50, 8'h60);
    release_reset();
    wait_log(360);
    for (int i = 0; i < 8; i++) chk($sformatf("frame_l3_b%0d", i), log_byte(192 + i), l3act[i]);
    chk("frame_uf_f0", count_uf(0, 119), 0);
    chk("frame_uf_f1", count_uf(120, 239), 0);
    chk("frame_uf_f2_starved", count_uf(240, 359), 12);
    chk("frame_synced", synced, 1);

    // SOP arriving at line 4 pixel 1 is held to the next frame-first slot
    assert_reset("rst_c");
    push_frame(5, 8'h20, 8'h30);
    push_frame(12, 8'hA0, 8'hB0);
    release_reset();
    wait_log(360);
    chk("held_black", log_byte(214), 8'h80);
    chk("held_no_uf", act_log[214][0], 0);
    chk("held_emit_c", log_byte(312), 8'hB0);
    chk("held_emit_y", log_byte(313), 8'hA0);
    chk("held_last_c", log_byte(358), 8'hBB);
    chk("held_last_y", log_byte(359), 8'hAB);
    chk("held_src_drained", src_q.size(), 0);

    // One missing pixel in an active C slot
    assert_reset("rst_d");
    push_frame(12, 8'h40, 8'h70);
    push_frame(12, 8'h40, 8'h70);
    gap_at = 196;
    release_reset();
    wait_log(240);
    chk("uf_prev_c", log_byte(194), 8'h71);
    chk("uf_prev_uf", act_log[195][0], 0);
    chk("uf_black_c", log_byte(196), 8'h80);
    chk("uf_black_y", log_byte(197), 8'h10);
    chk("uf_pulse", act_log[196][0], 1);
    chk("uf_pulse_end", act_log[197][0], 0);
    chk("uf_resume", log_byte(198), 8'h72);
    chk("uf_count_f1", count_uf(120, 239), 1);

    // Reset asserted at line 3, byte 12
    assert_reset("rst_e");
    push_frame(12, 8'h11, 8'h22);
    release_reset();
    t = 0;
    while (act_log.size() < 72 && t < 2000) begin
      @(posedge clk);
      #3;
      t++;
    end
    chk("midrst_reached", act_log.size(), 72);
    reset = 1'b1;
    #1;
    check_reset("midrst");
    release_reset();
    wait_log(1);
    chk("midrst_first_word", act_log[0], 12'hFF0);

    // Randomised frames with gaps and truncated frames
    assert_reset("rst_f");
    for (int fr = 0; fr < 10; fr++)
      push_frame(($urandom_range(3) == 0) ? $urandom_range(11, 4) : 12,
                 8'($urandom_range(255)), 8'($urandom_range(255)));
    valid_pct = 80;
    release_reset();
    wait_log(720);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
